// File: rtl/ifetch_if.sv
// ifetch_if: groups the fetch stage's memory request/response, redirect and decode channels.
// Latency: wires only, no storage.
// Backpressure: imem_req uses valid/ready, inst uses valid/ready, imem_resp and redirect have none.
//
// Ports (master = fetch stage, slave = memory/decode/branch side):
//   imem_req_valid/ready/addr   word-aligned fetch request
//   imem_resp_valid/data        in-order instruction response, always accepted
//   redirect_valid/pc           next-PC override from branch/jump resolution
//   inst_valid/ready, inst, inst_pc, opcode, funct3, funct7   head of the instruction buffer
interface ifetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, opcode, funct3, funct7,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, opcode, funct3, funct7,
    output inst_ready
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: holds the PC, issues word fetches and buffers returned instructions in order for decode.
// Latency: request accepted in N, response in N+k, instruction visible to decode in N+k+1.
// Backpressure: requests need a free credit (outstanding + buffered < DEPTH); responses are never stalled.
//
// Ports: clk, reset (synchronous, active-high), bus (ifetch_if.master: imem request/response,
//        redirect, decode head with split opcode/funct3/funct7 fields).
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic     clk,
  input  logic     reset,
  ifetch_if.master bus
);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc;
  // PC of the next response that will be kept. Requests are sequential between redirects and every
  // response older than a redirect is dropped, so this one register pairs each kept word with its address.
  logic [31:0]   resp_pc;
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_word [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   committed;
  logic          head_vld;
  logic          pop_req;
  logic          pop;
  logic          push;
  logic          resp_drop;
  logic          req_valid;
  logic          req_fire;
  logic [31:0]   redirect_tgt;
  logic [31:0]   head_word;
  logic [31:0]   head_pc;
  logic [1:0]    unused_redirect_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_vld  = (occupancy != '0);
    pop_req   = head_vld && bus.inst_ready;
    // Slots already promised: in-flight requests plus buffered words, net of this cycle's pop.
    committed = {1'b0, outstanding} + {1'b0, occupancy} - (CW+1)'(pop_req);
    req_valid = !reset && !bus.redirect_valid && (committed < (CW+1)'(DEPTH));
    req_fire  = req_valid && bus.imem_req_ready;
    // A redirect voids the pop and discards any response arriving with it.
    pop       = pop_req && !bus.redirect_valid;
    resp_drop = bus.imem_resp_valid && (drop_cnt != '0);
    push      = bus.imem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  end

  assign redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
      if (bus.redirect_valid) begin
        fetch_pc  <= redirect_tgt;
        resp_pc   <= redirect_tgt;
        head      <= '0;
        tail      <= '0;
        occupancy <= '0;
        // Everything still in flight after this cycle's response belongs to the old path.
        drop_cnt  <= outstanding - CW'(bus.imem_resp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          tail    <= ptr_inc(tail);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          head <= ptr_inc(head);
        end
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: the head is only exposed while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_pc[tail]   <= resp_pc;
      buf_word[tail] <= bus.imem_resp_data;
    end
  end

  assign head_word = head_vld ? buf_word[head] : '0;
  assign head_pc   = head_vld ? buf_pc[head]   : '0;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = head_vld;
  assign bus.inst           = head_word;
  assign bus.inst_pc        = head_pc;
  assign bus.opcode         = head_word[6:0];
  assign bus.funct3         = head_word[14:12];
  assign bus.funct7         = head_word[31:25];
endmodule
